// File: rtl/led_seq_if.sv
// Configuration handshake, run control and LED status bundle for led_seq_ctrl.
// master = controlling logic / bench, slave = the sequencer.
interface led_seq_if #(
  parameter int DIV_W = 27,
  parameter int LED_W = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIV_W-1:0] cfg_div;
  logic [1:0]       cfg_mode;
  logic [7:0]       cfg_reps;
  logic             start;
  logic             stop;
  logic             busy;
  logic             stb;
  logic             done;
  logic [LED_W-1:0] led;

  modport master (
    output cfg_valid, cfg_div, cfg_mode, cfg_reps, start, stop,
    input  cfg_ready, busy, stb, done, led
  );

  modport slave (
    input  cfg_valid, cfg_div, cfg_mode, cfg_reps, start, stop,
    output cfg_ready, busy, stb, done, led
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// Tick scheduler and LED pattern sequencer: divides clk into step strobes and
// walks the LED bank through a COUNT/SHIFT/BOUNCE/BLINK pattern for a set number of steps.
module led_seq_ctrl #(
  parameter int DIV_W   = 27,
  parameter int DEF_DIV = 100_000_000,
  parameter int LED_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  led_seq_if.slave   bus
);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  localparam logic [1:0]       M_COUNT  = 2'd0;
  localparam logic [1:0]       M_SHIFT  = 2'd1;
  localparam logic [1:0]       M_BOUNCE = 2'd2;
  localparam logic [1:0]       M_BLINK  = 2'd3;
  localparam logic [DIV_W-1:0] DEF_DIV_C = DIV_W'(DEF_DIV);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       mode_q, mode_d;
  logic [7:0]       reps_q, reps_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [7:0]       step_q, step_d;
  logic             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             stb_q, stb_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             cfg_ready_q, cfg_ready_d;
  logic [LED_W-1:0] led_nxt_s;
  logic             dir_nxt_s;

  function automatic logic [LED_W-1:0] init_led(input logic [1:0] mode);
    case (mode)
      M_SHIFT, M_BOUNCE: init_led = LED_W'(1);
      M_COUNT, M_BLINK:  init_led = '0;
      default:           init_led = '0;
    endcase
  endfunction

  // Next LED pattern and bounce direction for the current mode
  always_comb begin
    led_nxt_s = led_q;
    dir_nxt_s = dir_q;
    case (mode_q)
      M_COUNT: led_nxt_s = led_q + LED_W'(1);
      M_SHIFT: led_nxt_s = {led_q[LED_W-2:0], led_q[LED_W-1]};
      M_BOUNCE: begin
        if (!dir_q) begin
          led_nxt_s = led_q << 1;
          dir_nxt_s = led_nxt_s[LED_W-1];
        end else begin
          led_nxt_s = led_q >> 1;
          dir_nxt_s = ~led_nxt_s[0];
        end
      end
      M_BLINK: led_nxt_s = ~led_q;
      default: led_nxt_s = led_q;
    endcase
  end

  // State machine: configuration capture, run start, divider, steps and completion
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    mode_d  = mode_q;
    reps_d  = reps_q;
    cnt_d   = cnt_q;
    step_d  = step_q;
    dir_d   = dir_q;
    led_d   = led_q;
    stb_d   = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_valid) begin
          div_d  = (bus.cfg_div < DIV_W'(2)) ? DIV_W'(2) : bus.cfg_div;
          mode_d = bus.cfg_mode;
          reps_d = bus.cfg_reps;
        end else begin
          div_d  = div_q;
        end
        // A coincident handshake already supplies the mode for this run
        if (bus.start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          step_d  = 8'd0;
          dir_d   = 1'b0;
          led_d   = init_led(bus.cfg_valid ? bus.cfg_mode : mode_q);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
          cnt_d  = '0;
          stb_d  = 1'b1;
          led_d  = led_nxt_s;
          dir_d  = dir_nxt_s;
          step_d = step_q + 8'd1;
          if ((reps_q != 8'd0) && (step_d == reps_q)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d      = (state_d == S_RUN);
    cfg_ready_d = (state_d == S_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= DEF_DIV_C;
      mode_q      <= 2'd0;
      reps_q      <= 8'd0;
      cnt_q       <= '0;
      step_q      <= 8'd0;
      dir_q       <= 1'b0;
      led_q       <= '0;
      stb_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      mode_q      <= mode_d;
      reps_q      <= reps_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      dir_q       <= dir_d;
      led_q       <= led_d;
      stb_q       <= stb_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign bus.cfg_ready = cfg_ready_q;
  assign bus.busy      = busy_q;
  assign bus.stb       = stb_q;
  assign bus.done      = done_q;
  assign bus.led       = led_q;

endmodule
